// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: state encodings, PC-source select codes and exception cause codes shared by pc_control and pc_req_arbiter
package pc_ctrl_pkg;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_UPDATE    = 3'd1;
  localparam logic [2:0] ST_EXC_SAVE  = 3'd2;
  localparam logic [2:0] ST_VEC_FETCH = 3'd3;
  localparam logic [2:0] ST_VEC_LOAD  = 3'd4;
  localparam logic [2:0] SEL_LS      = 3'd0;
  localparam logic [2:0] SEL_ALU_RES = 3'd1;
  localparam logic [2:0] SEL_ALU_OUT = 3'd2;
  localparam logic [2:0] SEL_SHL2    = 3'd3;
  localparam logic [2:0] SEL_EPC     = 3'd4;
  localparam logic [1:0] EXC_OVF      = 2'd0;
  localparam logic [1:0] EXC_BAD_OP   = 2'd1;
  localparam logic [1:0] EXC_DIV0     = 2'd2;
  localparam logic [1:0] EXC_MISALIGN = 2'd3;
endpackage

// File: rtl/pc_req_arbiter.sv
// pc_req_arbiter: fixed-priority PC request select (exc > rfe > jr > jump > branch > inc); in: requests, br_taken; out: o_valid, o_exc, o_sel
module pc_req_arbiter
  import pc_ctrl_pkg::*;
(
  input  logic       i_inc,
  input  logic       i_branch,
  input  logic       i_br_taken,
  input  logic       i_jump,
  input  logic       i_jr,
  input  logic       i_rfe,
  input  logic       i_exc,
  output logic       o_valid,
  output logic       o_exc,
  output logic [2:0] o_sel
);
  assign o_valid = i_inc | i_branch | i_jump | i_jr | i_rfe | i_exc;
  assign o_exc = i_exc;
  assign o_sel = i_rfe ? SEL_EPC :
                 i_jr ? SEL_ALU_RES :
                 i_jump ? SEL_SHL2 :
                 (i_branch && i_br_taken) ? SEL_ALU_OUT : SEL_ALU_RES;
endmodule

// File: rtl/pc_control.sv
// pc_control: PC-update/exception-vector FSM (IDLE/UPDATE/EXC_SAVE/VEC_FETCH/VEC_LOAD), async active-low reset_n; ports: requests, exc_code, target_lsb in; muxpcsource, pc_write, epc_write, vec_addr, mem_read, busy, done out; PC_ALIGN_CHECK_EN turns misaligned targets into exc_code 3
module pc_control
  import pc_ctrl_pkg::*;
#(
  parameter int          VEC_WAIT = 2,
  parameter logic [31:0] VEC_BASE = 32'd253
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_inc,
  input  logic        req_branch,
  input  logic        br_taken,
  input  logic        req_jump,
  input  logic        req_jr,
  input  logic        req_rfe,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [1:0]  target_lsb,
  output logic [2:0]  muxpcsource,
  output logic        pc_write,
  output logic        epc_write,
  output logic [31:0] vec_addr,
  output logic        mem_read,
  output logic        busy,
  output logic        done
);
  logic [2:0] r_state, r_sel, r_cnt;
  logic [1:0] r_code;
  logic       w_valid, w_exc, w_fault;
  logic [2:0] w_sel;
  pc_req_arbiter u_arb (
    .i_inc      (req_inc),
    .i_branch   (req_branch),
    .i_br_taken (br_taken),
    .i_jump     (req_jump),
    .i_jr       (req_jr),
    .i_rfe      (req_rfe),
    .i_exc      (exc_req),
    .o_valid    (w_valid),
    .o_exc      (w_exc),
    .o_sel      (w_sel)
  );
`ifdef PC_ALIGN_CHECK_EN
  assign w_fault = w_valid && !w_exc && (target_lsb != 2'b00);
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^target_lsb;
  assign w_fault = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_sel   <= SEL_LS;
      r_cnt   <= 3'd0;
      r_code  <= EXC_OVF;
    end else
      case (r_state)
        ST_IDLE:
          if (w_exc || w_fault) begin
            r_state <= ST_EXC_SAVE;
            r_code  <= w_exc ? exc_code : EXC_MISALIGN;
          end else if (w_valid) begin
            r_state <= ST_UPDATE;
            r_sel   <= w_sel;
          end
        ST_UPDATE: r_state <= ST_IDLE;
        ST_EXC_SAVE: begin
          r_state <= ST_VEC_FETCH;
          r_cnt   <= 3'(VEC_WAIT - 1);
        end
        ST_VEC_FETCH:
          if (r_cnt == 3'd0) begin
            r_state <= ST_VEC_LOAD;
            r_sel   <= SEL_LS;
          end else
            r_cnt <= r_cnt - 3'd1;
        default: r_state <= ST_IDLE;
      endcase
  assign muxpcsource = r_sel;
  assign pc_write = (r_state == ST_UPDATE) || (r_state == ST_VEC_LOAD);
  assign done = pc_write;
  assign epc_write = (r_state == ST_EXC_SAVE);
  assign mem_read = (r_state == ST_VEC_FETCH);
  assign vec_addr = mem_read ? VEC_BASE + {30'd0, r_code} : 32'd0;
  assign busy = (r_state != ST_IDLE);
endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control: directed stimulus against a per-cycle expected-output schedule model plus literal spot checks
module tb_pc_control;
  localparam int          VW = 2;
  localparam logic [31:0] VB = 32'd253;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req_inc = 1'b0, req_branch = 1'b0, br_taken = 1'b0, req_jump = 1'b0;
  logic        req_jr = 1'b0, req_rfe = 1'b0, exc_req = 1'b0;
  logic [1:0]  exc_code = 2'd0, target_lsb = 2'd0;
  logic [2:0]  muxpcsource;
  logic        pc_write, epc_write, mem_read, busy, done;
  logic [31:0] vec_addr;
  pc_control #(.VEC_WAIT(VW), .VEC_BASE(VB)) dut (
    .clk(clk), .reset_n(reset_n), .req_inc(req_inc), .req_branch(req_branch),
    .br_taken(br_taken), .req_jump(req_jump), .req_jr(req_jr), .req_rfe(req_rfe),
    .exc_req(exc_req), .exc_code(exc_code), .target_lsb(target_lsb),
    .muxpcsource(muxpcsource), .pc_write(pc_write), .epc_write(epc_write),
    .vec_addr(vec_addr), .mem_read(mem_read), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit          hold;
    logic [2:0]  mux;
    bit          pc;
    bit          epc;
    bit          mr;
    bit          bsy;
    logic [31:0] addr;
  } rec_t;
  rec_t       cur;
  rec_t       q[$];
  logic [2:0] last_mux;
  int         n_cmp = 0, n_fail = 0;
  task automatic model_reset();
    q.delete();
    last_mux = 3'd0;
    cur = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
  endtask
  task automatic push_exc(input logic [1:0] c);
    q.push_back('{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0});
    for (int i = 0; i < VW; i++) q.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, VB + 32'(c)});
    q.push_back('{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0});
  endtask
  task automatic model_edge();
    rec_t n;
    int   s;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (!cur.bsy) begin
      s = -1;
      if (exc_req) push_exc(exc_code);
      else begin
        if (req_rfe) s = 4;
        else if (req_jr) s = 1;
        else if (req_jump) s = 3;
        else if (req_branch) s = br_taken ? 2 : 1;
        else if (req_inc) s = 1;
`ifdef PC_ALIGN_CHECK_EN
        if (s >= 0 && target_lsb != 2'd0) push_exc(2'd3); else
`endif
        if (s >= 0) q.push_back('{1'b0, 3'(s), 1'b1, 1'b0, 1'b0, 1'b1, 32'd0});
      end
    end
    if (q.size() > 0) n = q.pop_front();
    else n = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    if (n.hold) n.mux = last_mux;
    else last_mux = n.mux;
    cur = n;
  endtask
  task automatic cmp();
    n_cmp++;
    if (muxpcsource !== cur.mux || pc_write !== cur.pc || done !== cur.pc || epc_write !== cur.epc ||
        mem_read !== cur.mr || vec_addr !== cur.addr || busy !== cur.bsy) begin
      n_fail++;
      $display("FAIL cycle @%0t got mux=%0d pc=%0d done=%0d epc=%0d mr=%0d addr=%0d busy=%0d want mux=%0d pc=%0d done=%0d epc=%0d mr=%0d addr=%0d busy=%0d",
               $time, muxpcsource, pc_write, done, epc_write, mem_read, vec_addr, busy,
               cur.mux, cur.pc, cur.pc, cur.epc, cur.mr, cur.addr, cur.bsy);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cmp();
  endtask
  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask
  task automatic clr();
    {req_inc, req_branch, br_taken, req_jump, req_jr, req_rfe, exc_req} = '0;
    exc_code = 2'd0;
    target_lsb = 2'd0;
  endtask
  initial begin
    model_reset();
    tick(); tick();
    lit("rst_mux", 32'(muxpcsource), 0);
    lit("rst_busy", 32'(busy), 0);
    #2 reset_n = 1'b1;
    req_inc = 1'b1; tick(); clr();
    lit("inc_mux", 32'(muxpcsource), 1);
    lit("inc_pcw", 32'(pc_write), 1);
    lit("inc_done", 32'(done), 1);
    lit("inc_busy", 32'(busy), 1);
    tick();
    lit("inc_busy_after", 32'(busy), 0);
    lit("inc_hold_mux", 32'(muxpcsource), 1);
    req_jump = 1'b1; req_branch = 1'b1; br_taken = 1'b1; tick(); clr();
    lit("jump_over_branch", 32'(muxpcsource), 3);
    tick();
    req_branch = 1'b1; tick(); clr();
    lit("branch_not_taken", 32'(muxpcsource), 1);
    tick();
    req_branch = 1'b1; br_taken = 1'b1; tick(); clr();
    lit("branch_taken", 32'(muxpcsource), 2);
    tick();
    exc_req = 1'b1; exc_code = 2'd2; tick(); clr();
    lit("exc_epcw", 32'(epc_write), 1);
    lit("exc_no_pcw", 32'(pc_write), 0);
    tick();
    lit("exc_mr1", 32'(mem_read), 1);
    lit("exc_addr1", vec_addr, 255);
    req_rfe = 1'b1; tick();
    lit("exc_addr2", vec_addr, 255);
    tick(); req_rfe = 1'b0;
    lit("vload_mux", 32'(muxpcsource), 0);
    lit("vload_pcw", 32'(pc_write), 1);
    tick();
    lit("rfe_ignored_idle", 32'(busy), 0);
    req_rfe = 1'b1; tick(); clr();
    lit("rfe_mux", 32'(muxpcsource), 4);
    lit("rfe_pcw", 32'(pc_write), 1);
    tick();
    {req_inc, req_branch, br_taken, req_jump, req_jr, req_rfe, exc_req} = '1;
    exc_code = 2'd0; tick(); clr();
    lit("prio_exc", 32'(epc_write), 1);
    tick();
    lit("prio_addr", vec_addr, 253);
    tick(); tick(); tick();
    req_rfe = 1'b1; req_jr = 1'b1; tick(); clr();
    lit("rfe_over_jr", 32'(muxpcsource), 4);
    tick();
    req_jr = 1'b1; req_jump = 1'b1; tick(); clr();
    lit("jr_over_jump", 32'(muxpcsource), 1);
    tick();
    exc_req = 1'b1; exc_code = 2'd3; tick(); clr();
    tick();
    lit("code3_addr", vec_addr, 256);
    tick(); tick(); tick();
    req_jr = 1'b1; target_lsb = 2'b10; tick(); clr();
`ifdef PC_ALIGN_CHECK_EN
    lit("align_no_pcw", 32'(pc_write), 0);
    lit("align_epcw", 32'(epc_write), 1);
    tick();
    lit("align_addr", vec_addr, 256);
    tick(); tick(); tick();
`else
    lit("lsb_ignored_pcw", 32'(pc_write), 1);
    lit("lsb_ignored_mux", 32'(muxpcsource), 1);
    tick();
`endif
    req_jump = 1'b1; tick(); clr(); tick();
    exc_req = 1'b1; exc_code = 2'd1; tick(); clr();
    tick();
    lit("pre_rst_addr", vec_addr, 254);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    lit("arst_busy", 32'(busy), 0);
    lit("arst_mr", 32'(mem_read), 0);
    lit("arst_addr", vec_addr, 0);
    lit("arst_mux", 32'(muxpcsource), 0);
    lit("arst_pcw_epcw", {30'd0, pc_write, epc_write}, 0);
    tick();
    reset_n = 1'b1;
    req_jr = 1'b1; tick(); clr();
    lit("post_rst_jr", 32'(muxpcsource), 1);
    lit("post_rst_pcw", 32'(pc_write), 1);
    tick();
    exc_req = 1'b1; exc_code = 2'd0; tick(); clr();
    tick(); tick(); tick();
    lit("post_rst_vload", 32'(pc_write), 1);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
